// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush generator for the 5-stage pipeline (IF=0, ID=1, EX=2,
// MEM=3, WB=4). stall[k]/flush[k] control the register feeding stage k, so
// stall[0] holds the PC. Stall requests are arbitrated every cycle, and
// exceptions/ERET taken at MEM are sequenced into a flush, a one-cycle PC
// redirect and, for exceptions, a one-cycle CP0 commit pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   req_stall      per-stage stall request (bit k: stage k cannot complete)
//   exc_valid      exception detected on the instruction in MEM
//   exc_pc         PC of the faulting instruction
//   exc_cause      exception cause code
//   eret_valid     ERET in MEM
//   eret_target    EPC from CP0
//   stall          per-stage stall (combinational)
//   flush          per-stage flush (combinational)
//   redirect_valid PC redirect pulse (registered, one cycle per event)
//   redirect_pc    redirect target
//   exc_commit     one-cycle pulse to CP0: latch epc/cause
//   epc            registered faulting PC
//   cause          registered cause code
//   busy           controller is not in RUN
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int                   STAGES      = 5,
    parameter int                   MEM_STAGE   = 3,
    parameter int                   PC_WIDTH    = 32,
    parameter int                   CAUSE_WIDTH = 5,
    parameter logic [PC_WIDTH-1:0]  EXC_VECTOR  = 32'hBFC00380
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STAGES-1:0]       req_stall,
    input  logic                    exc_valid,
    input  logic [PC_WIDTH-1:0]     exc_pc,
    input  logic [CAUSE_WIDTH-1:0]  exc_cause,
    input  logic                    eret_valid,
    input  logic [PC_WIDTH-1:0]     eret_target,
    output logic [STAGES-1:0]       stall,
    output logic [STAGES-1:0]       flush,
    output logic                    redirect_valid,
    output logic [PC_WIDTH-1:0]     redirect_pc,
    output logic                    exc_commit,
    output logic [PC_WIDTH-1:0]     epc,
    output logic [CAUSE_WIDTH-1:0]  cause,
    output logic                    busy
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EXC_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Stages 0..MEM_STAGE held while an event waits for MEM/WB to drain.
    localparam logic [STAGES-1:0] HOLD_MASK   = {STAGES{1'b1}} >> (STAGES - 1 - MEM_STAGE);
    // Faulting instruction and everything younger killed; only the PC held.
    localparam logic [STAGES-1:0] FLUSH_YOUNG = {{(STAGES-1){1'b1}}, 1'b0};
    localparam logic [STAGES-1:0] STALL_PC    = {{(STAGES-1){1'b0}}, 1'b1};
    // Wrong-path fetch discarded during the redirect cycle.
    localparam logic [STAGES-1:0] FLUSH_IF    = {{(STAGES-2){1'b0}}, 2'b10};

    state_t                 state, state_nxt;

    // Event parked while MEM/WB are stalled (first event wins).
    logic                   pend_exc;
    logic [PC_WIDTH-1:0]    pend_pc;
    logic [CAUSE_WIDTH-1:0] pend_cause;
    logic [PC_WIDTH-1:0]    pend_target;

    // Type of the event currently being redirected.
    logic                   cur_exc;

    logic                   event_req;
    logic                   mem_blocked;
    logic                   take_now;
    logic                   park;
    logic                   take_pend;
    logic [STAGES-1:0]      run_stall;

    assign event_req   = exc_valid | eret_valid;
    assign mem_blocked = |req_stall[STAGES-1:MEM_STAGE];
    assign take_now    = (state == RUN) && event_req && !mem_blocked;
    assign park        = (state == RUN) && event_req &&  mem_blocked;
    assign take_pend   = (state == EXC_WAIT) && !mem_blocked;

    // Normal arbitration: every stage at or below the highest requester stalls.
    always_comb begin
        logic acc;
        // NOTE: every variable written in a combinational block gets a default
        // first; otherwise a path that skips the assignment infers a latch.
        acc       = 1'b0;
        run_stall = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc          = acc | req_stall[k];
            run_stall[k] = acc;
        end
    end

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:      if (take_now)  state_nxt = REDIRECT;
                      else if (park) state_nxt = EXC_WAIT;
            EXC_WAIT: if (take_pend) state_nxt = REDIRECT;
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        stall = '0;
        flush = '0;
        // Reset is a level here too: stall/flush read 0 throughout reset.
        if (rst) begin
            unique case (state)
                RUN: begin
                    if (take_now) begin
                        flush = FLUSH_YOUNG;
                        stall = STALL_PC;
                    end else if (park) begin
                        stall = run_stall | HOLD_MASK;
                    end else begin
                        stall = run_stall;
                    end
                end
                EXC_WAIT: begin
                    if (take_pend) begin
                        flush = FLUSH_YOUNG;
                        stall = STALL_PC;
                    end else begin
                        stall = run_stall | HOLD_MASK;
                    end
                end
                REDIRECT: flush = FLUSH_IF;
                default:  ;
            endcase
        end
    end

    // Pulses are decoded from the state register, so an asynchronous reset
    // clears them at once without waiting for a clock edge.
    assign redirect_valid = (state == REDIRECT);
    assign exc_commit     = (state == REDIRECT) && cur_exc;
    assign busy           = (state != RUN);

    // ----------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: these are a handful of flops, not a memory array, so all of
            // them are reset to give well-defined outputs straight out of reset.
            redirect_pc <= '0;
            epc         <= '0;
            cause       <= '0;
            cur_exc     <= 1'b0;
            pend_exc    <= 1'b0;
            pend_pc     <= '0;
            pend_cause  <= '0;
            pend_target <= '0;
        end else if (take_now) begin
            // Exception wins over a simultaneous ERET.
            cur_exc     <= exc_valid;
            redirect_pc <= exc_valid ? EXC_VECTOR : eret_target;
            if (exc_valid) begin
                epc   <= exc_pc;
                cause <= exc_cause;
            end
        end else if (park) begin
            pend_exc    <= exc_valid;
            pend_pc     <= exc_pc;
            pend_cause  <= exc_cause;
            pend_target <= exc_valid ? EXC_VECTOR : eret_target;
        end else if (take_pend) begin
            cur_exc     <= pend_exc;
            redirect_pc <= pend_target;
            if (pend_exc) begin
                epc   <= pend_pc;
                cause <= pend_cause;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pipeline_hazard_ctrl. Each driven cycle pushes its
// expected outputs to a queue; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;

    logic        clk;
    logic        rst;
    logic [4:0]  req_stall;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [4:0]  exc_cause;
    logic        eret_valid;
    logic [31:0] eret_target;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_commit;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        busy;

    pipeline_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_stall      (req_stall),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .exc_cause      (exc_cause),
        .eret_valid     (eret_valid),
        .eret_target    (eret_target),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_commit     (exc_commit),
        .epc            (epc),
        .cause          (cause),
        .busy           (busy)
    );

    // Starts high: negedge at 5, posedge at 10; inputs change at posedge+1.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        rv;
        logic        commit;
        logic        busy;
        logic [31:0] rpc;
        logic [31:0] epc;
        logic [4:0]  cause;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural values the bench expects to be held in the registers.
    logic [31:0] exp_rpc   = '0;
    logic [31:0] exp_epc   = '0;
    logic [4:0]  exp_cause = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Push this cycle's expectation, then advance to the next drive point.
    task automatic expect_cycle(input string tag, input logic [4:0] e_stall,
                                input logic [4:0] e_flush, input logic e_rv,
                                input logic e_commit, input logic e_busy);
        exp_t e;
        e.tag    = tag;
        e.stall  = e_stall;
        e.flush  = e_flush;
        e.rv     = e_rv;
        e.commit = e_commit;
        e.busy   = e_busy;
        e.rpc    = exp_rpc;
        e.epc    = exp_epc;
        e.cause  = exp_cause;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_stall  = '0;
        exc_valid  = 1'b0;
        eret_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".stall"},  32'(stall),          32'(e.stall));
            check({e.tag, ".flush"},  32'(flush),          32'(e.flush));
            check({e.tag, ".rv"},     32'(redirect_valid), 32'(e.rv));
            check({e.tag, ".commit"}, 32'(exc_commit),     32'(e.commit));
            check({e.tag, ".busy"},   32'(busy),           32'(e.busy));
            check({e.tag, ".rpc"},    redirect_pc,         e.rpc);
            check({e.tag, ".epc"},    epc,                 e.epc);
            check({e.tag, ".cause"},  32'(cause),          32'(e.cause));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------------------------------------------------- reset
        rst         = 1'b0;
        req_stall   = 5'b11111;
        exc_valid   = 1'b1;
        exc_pc      = 32'hDEAD_BEEF;
        exc_cause   = 5'd31;
        eret_valid  = 1'b0;
        eret_target = 32'h0;
        expect_cycle("reset0", 5'b00000, 5'b00000, 0, 0, 0);
        expect_cycle("reset1", 5'b00000, 5'b00000, 0, 0, 0);
        rst = 1'b1;
        idle_inputs();
        expect_cycle("post_reset", 5'b00000, 5'b00000, 0, 0, 0);

        // -------------------------------------------------- arbitration
        req_stall = 5'b00100;
        expect_cycle("arb_ex", 5'b00111, 5'b00000, 0, 0, 0);
        req_stall = 5'b00010;
        expect_cycle("arb_id", 5'b00011, 5'b00000, 0, 0, 0);
        req_stall = 5'b10010;
        expect_cycle("arb_wb", 5'b11111, 5'b00000, 0, 0, 0);
        req_stall = 5'b00001;
        expect_cycle("arb_if", 5'b00001, 5'b00000, 0, 0, 0);
        idle_inputs();
        expect_cycle("arb_none", 5'b00000, 5'b00000, 0, 0, 0);

        // ------------------------------------------- exception in RUN
        exc_valid = 1'b1;
        exc_pc    = 32'h8000_0010;
        exc_cause = 5'd12;
        expect_cycle("exc_t", 5'b00001, 5'b11110, 0, 0, 0);
        idle_inputs();
        exp_rpc = EXC_VEC; exp_epc = 32'h8000_0010; exp_cause = 5'd12;
        expect_cycle("exc_t1", 5'b00000, 5'b00010, 1, 1, 1);
        expect_cycle("exc_t2", 5'b00000, 5'b00000, 0, 0, 0);

        // ---------------------------------------------- blocked exception
        req_stall = 5'b01000;
        exc_valid = 1'b1;
        exc_pc    = 32'hA000_0040;
        exc_cause = 5'd4;
        expect_cycle("blk_park", 5'b01111, 5'b00000, 0, 0, 0);
        exc_pc    = 32'h9000_0000;
        exc_cause = 5'd7;
        for (int i = 0; i < 3; i++)
            expect_cycle($sformatf("blk_wait%0d", i), 5'b01111, 5'b00000, 0, 0, 1);
        idle_inputs();
        expect_cycle("blk_accept", 5'b00001, 5'b11110, 0, 0, 1);
        exp_epc = 32'hA000_0040; exp_cause = 5'd4;
        expect_cycle("blk_redir", 5'b00000, 5'b00010, 1, 1, 1);
        expect_cycle("blk_done", 5'b00000, 5'b00000, 0, 0, 0);

        // -------------- simultaneous exc+eret; req_stall below MEM does not block
        req_stall   = 5'b00100;
        exc_valid   = 1'b1;
        exc_pc      = 32'h8000_0020;
        exc_cause   = 5'd3;
        eret_valid  = 1'b1;
        eret_target = 32'h8000_0100;
        expect_cycle("both_t", 5'b00001, 5'b11110, 0, 0, 0);
        idle_inputs();
        exp_rpc = EXC_VEC; exp_epc = 32'h8000_0020; exp_cause = 5'd3;
        expect_cycle("both_redir", 5'b00000, 5'b00010, 1, 1, 1);
        expect_cycle("both_done", 5'b00000, 5'b00000, 0, 0, 0);

        // ------------------------------- ERET alone; event in REDIRECT ignored
        eret_valid = 1'b1;
        expect_cycle("eret_t", 5'b00001, 5'b11110, 0, 0, 0);
        eret_valid = 1'b0;
        exc_valid  = 1'b1;
        exc_pc     = 32'hFFFF_0000;
        exc_cause  = 5'd1;
        exp_rpc = 32'h8000_0100;
        expect_cycle("eret_redir", 5'b00000, 5'b00010, 1, 0, 1);
        idle_inputs();
        expect_cycle("eret_done", 5'b00000, 5'b00000, 0, 0, 0);

        // ------------------------------------------ async reset in REDIRECT
        exc_valid = 1'b1;
        exc_pc    = 32'h8000_0030;
        exc_cause = 5'd9;
        expect_cycle("ar_t", 5'b00001, 5'b11110, 0, 0, 0);
        idle_inputs();
        #1;
        check("ar_redir_rv", 32'(redirect_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("ar_rv_drop",     32'(redirect_valid), 32'd0);
        check("ar_commit_drop", 32'(exc_commit),     32'd0);
        check("ar_busy_drop",   32'(busy),           32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_rpc = '0; exp_epc = '0; exp_cause = '0;
        expect_cycle("ar_after0", 5'b00000, 5'b00000, 0, 0, 0);
        expect_cycle("ar_after1", 5'b00000, 5'b00000, 0, 0, 0);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush generator for the 5-stage pipeline (IF=0, ID=1, EX=2, MEM=3, WB=4).
- Drives the per-stage `stall`/`flush` controls consumed by the inter-stage pipeline registers.
- Arbitrates stage stall requests and sequences precise exceptions/ERET taken at MEM.
- Emits the PC redirect and the CP0 commit pulse.
- `flush[k]` and `stall[k]` refer to the register feeding stage k, i.e. the register whose input is stage k-1's output; `stall[0]` holds the PC.

Parameters:
STAGES, 5, number of pipeline stages (stall/flush vector width)
MEM_STAGE, 3, index of stage where exceptions/ERET are taken
PC_WIDTH, 32, PC/target width
CAUSE_WIDTH, 5, exception cause code width
EXC_VECTOR, 32'hBFC00380, exception handler address

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_stall  in  STAGES  per-stage stall request (bit k: stage k cannot complete this cycle)
exc_valid  in  1  exception detected on instruction in MEM
exc_pc  in  PC_WIDTH  PC of faulting instruction
exc_cause  in  CAUSE_WIDTH  cause code
eret_valid  in  1  ERET in MEM
eret_target  in  PC_WIDTH  EPC from CP0
stall  out  STAGES  per-stage stall, combinational
flush  out  STAGES  per-stage flush, combinational
redirect_valid  out  1  PC redirect pulse
redirect_pc  out  PC_WIDTH  redirect target
exc_commit  out  1  one-cycle pulse to CP0: latch epc/cause
epc  out  PC_WIDTH  registered faulting PC
cause  out  CAUSE_WIDTH  registered cause
busy  out  1  controller not in RUN

Behaviour:
- Reset (rst=0, async):
  - state=RUN.
  - redirect_valid, exc_commit, epc, cause, redirect_pc all 0.
  - Combinational stall/flush outputs evaluate to 0 while in reset.
- States: RUN, EXC_WAIT, REDIRECT.
- RUN, no event:
  - h = highest set bit of req_stall.
  - stall[k]=1 for all k<=h, else 0. Downstream registers then insert a bubble between h and h+1.
  - req_stall=0 gives stall=0.
  - flush=0.
- Event accepted (RUN, cycle t): exc_valid or eret_valid asserted, and no req_stall bit at index >= MEM_STAGE.
  - If both are set, the exception has priority and the ERET is ignored.
  - Cycle t, combinational: flush[k]=1 for k=1..STAGES-1 (faulting instruction blocked from WB, all younger killed); stall[0]=1; all other stall bits 0.
  - Edge at end of t: latch target (EXC_VECTOR for exception, eret_target for ERET) into redirect_pc.
  - For an exception, also latch exc_pc into epc and exc_cause into cause. For an ERET, epc/cause are unchanged.
  - state→REDIRECT.
- Event blocked (RUN, event present but a req_stall bit at index >= MEM_STAGE is set, e.g. outstanding bus access):
  - Latch event type, pc, cause and target; state→EXC_WAIT.
  - stall follows the normal RUN rule, with stall[0..MEM_STAGE] forced to 1.
- EXC_WAIT:
  - stall[0..MEM_STAGE]=1; new exc_valid/eret_valid ignored (first event wins).
  - When no req_stall bit >= MEM_STAGE is set, perform the accept actions of cycle t using the latched values; state→REDIRECT.
- REDIRECT (exactly 1 cycle):
  - redirect_valid=1.
  - exc_commit=1 only for an exception, not for ERET.
  - flush[1]=1 (discard wrong-path fetch); stall=0.
  - Input events are ignored.
  - state→RUN.
- redirect_valid and exc_commit are registered, state-decoded pulses: exactly one cycle per event.
- busy=1 in EXC_WAIT and REDIRECT.
- Reset asserted mid-EXC_WAIT or mid-REDIRECT: immediate return to RUN; no redirect or commit pulse afterwards.
- req_stall bits are level-sampled every cycle; no internal storage of stall requests.

Test Plan:
- Reset: hold rst=0 with req_stall=5'b11111 and exc_valid=1 → stall=0, flush=0, redirect_valid=0, epc=0. Release rst → RUN, busy=0.
- Stall arbitration: req_stall=5'b00100 → stall=5'b00111, flush=0. Then req_stall=5'b00010 → stall=5'b00011. Then req_stall=5'b10010 → stall=5'b11111.
- Exception in RUN: exc_valid=1, exc_pc=32'h8000_0010, cause=5'd12 at cycle t →
  - cycle t: flush=5'b11110, stall=5'b00001.
  - cycle t+1: redirect_valid=1, redirect_pc=32'hBFC00380, exc_commit=1, epc=32'h8000_0010, cause=12, flush=5'b00010.
  - cycle t+2: all pulses 0.
- Blocked exception: exc_valid with req_stall[3]=1 for 3 cycles → busy=1 and stall=5'b01111 for those 3 cycles, with a second exc_valid (exc_pc=32'h9000_0000) during the wait ignored. Accept on the 4th cycle; redirect one cycle later with the original epc.
- Simultaneous exc_valid and eret_valid (eret_target=32'h8000_0100) → exception taken: redirect_pc=EXC_VECTOR, exc_commit=1. A subsequent ERET alone → redirect_pc=32'h8000_0100, exc_commit=0, epc unchanged.
- Async reset in REDIRECT: drop rst mid-cycle → redirect_valid falls immediately without a clock edge, state=RUN after release, no further pulse.
